// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of every signal between the data-memory arbiter, its two requesters
// (core LSU on c_*, DMA/debug loader on d_*) and data_memory (mem_*).
//   c_req/c_we/c_addr/c_wdata    core request, held until c_ack
//   c_ack/c_rdata/c_err          core one-cycle completion
//   d_*                          same for the DMA/debug port
//   mem_read/mem_write/mem_address/mem_write_data  arbiter -> data_memory
//   mem_read_data                data_memory -> arbiter (combinational read)
//   busy                         arbiter sequencer not idle
// Modports: slave = arbiter side, master = requesters + memory side.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              c_req, c_we, c_ack, c_err;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;
    logic              d_req, d_we, d_ack, d_err;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;
    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_read_data,
        output c_ack, c_rdata, c_err,
        output d_ack, d_rdata, d_err,
        output mem_read, mem_write, mem_address, mem_write_data,
        output busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_read_data,
        input  c_ack, c_rdata, c_err,
        input  d_ack, d_rdata, d_err,
        input  mem_read, mem_write, mem_address, mem_write_data,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the core load/store path (c_*)
// and a DMA/debug loader (d_*). Three-state sequencer: IDLE picks a winner and
// registers its request, ACCESS drives the memory for one cycle and captures
// read data, RESP pulses the winner's ack with rdata/err.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave (requests, acks, mem_* lines, busy)
// Configuration:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> core always wins ties (DMA may starve)
//                           undefined -> round robin on ties, core first
// All outputs are registered and return to 0 whenever they are not active.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic CORE = 1'b0;
    localparam logic DMA  = 1'b1;

    typedef struct packed {
        logic              id;
        logic              we;
        logic              mis;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state;
    req_t              cur;
    req_t              pick;
    logic              win;
    logic [DATA_W-1:0] rd;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    // Winner selection and the request it would register this cycle.
    always_comb begin
        win = CORE;
        if (bus.c_req && bus.d_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win = CORE;
`else
            win = (last_grant == CORE) ? DMA : CORE;
`endif
        end else if (bus.d_req) begin
            win = DMA;
        end
        pick.id    = win;
        pick.we    = (win == DMA) ? bus.d_we    : bus.c_we;
        pick.addr  = (win == DMA) ? bus.d_addr  : bus.c_addr;
        pick.wdata = (win == DMA) ? bus.d_wdata : bus.c_wdata;
        pick.mis   = (win == DMA) ? (bus.d_addr[1:0] != 2'b00)
                                  : (bus.c_addr[1:0] != 2'b00);
    end

    // Only aligned reads return memory data; writes and misaligned accesses return 0.
    assign rd       = (!cur.we && !cur.mis) ? bus.mem_read_data : '0;
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cur                <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant         <= DMA;   // first tie after reset goes to the core
`endif
            bus.c_ack          <= 1'b0;
            bus.c_rdata        <= '0;
            bus.c_err          <= 1'b0;
            bus.d_ack          <= 1'b0;
            bus.d_rdata        <= '0;
            bus.d_err          <= 1'b0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
        end else begin
            // Everything defaults to 0; each state raises only what it owns.
            bus.c_ack          <= 1'b0;
            bus.c_rdata        <= '0;
            bus.c_err          <= 1'b0;
            bus.d_ack          <= 1'b0;
            bus.d_rdata        <= '0;
            bus.d_err          <= 1'b0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            case (state)
                IDLE: begin
                    if (bus.c_req || bus.d_req) begin
                        cur                <= pick;
                        // Misaligned accesses walk through ACCESS with strobes low.
                        bus.mem_read       <= !pick.we && !pick.mis;
                        bus.mem_write      <=  pick.we && !pick.mis;
                        bus.mem_address    <= pick.addr;
                        bus.mem_write_data <= pick.wdata;
                        state              <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (cur.id == DMA) begin
                        bus.d_ack   <= 1'b1;
                        bus.d_err   <= cur.mis;
                        bus.d_rdata <= rd;
                    end else begin
                        bus.c_ack   <= 1'b1;
                        bus.c_err   <= cur.mis;
                        bus.c_rdata <= rd;
                    end
                end
                RESP: begin
                    state      <= IDLE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_grant <= cur.id;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Table of single transactions plus hand-written sequences (back-to-back,
// reset mid-access, simultaneous requests). Expected acks are queued when a
// request is issued and popped by a negedge monitor when an ack appears.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Simple data memory: 32 words indexed by addr[6:2], combinational read.
    logic [63:0] tmem [0:31] = '{default: 64'd0};
    assign bus.mem_read_data = tmem[bus.mem_address[6:2]];
    always @(posedge clk) if (bus.mem_write) tmem[bus.mem_address[6:2]] <= bus.mem_write_data;

    typedef struct {
        logic        id;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [63:0] rdata, input logic err);
        exp_t e;
        e.id = id; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic id, input logic req, input logic we,
                         input logic [63:0] a, input logic [63:0] w);
        if (id) begin
            bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = w;
        end else begin
            bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = w;
        end
    endtask

    // Scoreboard and always-on output checks.
    exp_t mon_e;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 1'b0;
        end else begin
            if (bus.c_ack || bus.d_ack) begin
                chk("ack_exclusive", bus.c_ack & bus.d_ack, 1'b0);
                chk("ack_two_cycles", prev_ack, 1'b0);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: got c_ack=%0b d_ack=%0b expected none", bus.c_ack, bus.d_ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_id", bus.d_ack, mon_e.id);
                    chk("rdata", mon_e.id ? bus.d_rdata : bus.c_rdata, mon_e.rdata);
                    chk("err", mon_e.id ? bus.d_err : bus.c_err, mon_e.err);
                    chk("loser_quiet", mon_e.id ? (|{bus.c_rdata, bus.c_err}) : (|{bus.d_rdata, bus.d_err}), 1'b0);
                end
            end else begin
                chk("rdata_err_without_ack", |{bus.c_rdata, bus.d_rdata, bus.c_err, bus.d_err}, 1'b0);
            end
            if (!bus.busy)
                chk("mem_idle_zero", |{bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data}, 1'b0);
            prev_ack = bus.c_ack | bus.d_ack;
        end
    end

    // One isolated transaction: latency, address/data on the bus, strobe counts.
    task automatic run_vec(input vec_t v, input int idx);
        int   cyc, wc, rc;
        logic got, mis;
        mis = |v.addr[1:0];
        push_exp(v.id, v.rdata, v.err);
        drive(v.id, 1'b1, v.we, v.addr, v.wdata);
        cyc = 0; got = 1'b0; wc = 0; rc = 0;
        while (!got && cyc < 8) begin
            @(posedge clk); cyc++; @(negedge clk);
            wc += int'(bus.mem_write); rc += int'(bus.mem_read);
            if (cyc == 1 && !mis) chk($sformatf("vec%0d_mem_address", idx), bus.mem_address, v.addr);
            if (cyc == 1 && !mis && v.we) chk($sformatf("vec%0d_mem_wdata", idx), bus.mem_write_data, v.wdata);
            got = v.id ? bus.d_ack : bus.c_ack;
        end
        chk($sformatf("vec%0d_latency", idx), got ? cyc : 99, 2);
        drive(v.id, 1'b0, 1'b0, 64'd0, 64'd0);
        @(posedge clk); @(negedge clk);
        wc += int'(bus.mem_write); rc += int'(bus.mem_read);
        chk($sformatf("vec%0d_write_cycles", idx), wc, (v.we && !mis) ? 1 : 0);
        chk($sformatf("vec%0d_read_cycles", idx), rc, (!v.we && !mis) ? 1 : 0);
        chk($sformatf("vec%0d_busy_after", idx), bus.busy, 1'b0);
    endtask

    function automatic vec_t mk(input logic id, input logic we, input logic [63:0] a,
                                input logic [63:0] w, input logic [63:0] r, input logic e);
        vec_t v;
        v.id = id; v.we = we; v.addr = a; v.wdata = w; v.rdata = r; v.err = e;
        return v;
    endfunction

    vec_t vecs [10];
    int   nacks, nd;

    initial begin
        vecs[0] = mk(1'b0, 1'b1, 64'h08, 64'hDEAD, 64'h0,    1'b0); // core write
        vecs[1] = mk(1'b0, 1'b0, 64'h08, 64'h0,    64'hDEAD, 1'b0); // core read back
        vecs[2] = mk(1'b1, 1'b1, 64'h10, 64'hBEEF, 64'h0,    1'b0); // DMA write
        vecs[3] = mk(1'b1, 1'b0, 64'h10, 64'h0,    64'hBEEF, 1'b0); // DMA read back
        vecs[4] = mk(1'b0, 1'b0, 64'h10, 64'h0,    64'hBEEF, 1'b0); // core sees DMA data
        vecs[5] = mk(1'b1, 1'b0, 64'h06, 64'h0,    64'h0,    1'b1); // misaligned DMA read
        vecs[6] = mk(1'b0, 1'b1, 64'h05, 64'h1234, 64'h0,    1'b1); // misaligned core write
        vecs[7] = mk(1'b0, 1'b0, 64'h04, 64'h0,    64'h0,    1'b0); // word untouched by vec 6
        vecs[8] = mk(1'b1, 1'b1, 64'hFC, 64'hA5A5, 64'h0,    1'b0); // top word
        vecs[9] = mk(1'b1, 1'b0, 64'hFC, 64'h0,    64'hA5A5, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

        // Reset state, with a request pending to show it is ignored.
        bus.c_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_acks", {bus.c_ack, bus.d_ack}, 2'b00);
        chk("rst_rdata_err", |{bus.c_rdata, bus.d_rdata, bus.c_err, bus.d_err}, 1'b0);
        chk("rst_mem", |{bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data}, 1'b0);
        bus.c_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Core holds req through its ack: second access follows in the next IDLE.
        push_exp(1'b0, 64'hDEAD, 1'b0);
        push_exp(1'b0, 64'hDEAD, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 64'h08, 64'd0);
        nacks = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.c_ack) begin chk("b2b_ack_time", k, 2 + 3 * nacks); nacks++; end
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("b2b_ack_count", nacks, 2);
        repeat (2) @(negedge clk);

        // Reset lands in the middle of an ACCESS write.
        drive(1'b0, 1'b1, 1'b1, 64'h20, 64'h77);
        @(posedge clk); #1;
        chk("rstmid_write_issued", bus.mem_write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_write_dropped", bus.mem_write, 1'b0);
        chk("rstmid_busy", bus.busy, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("rstmid_no_update", tmem[8], 64'd0);
        rst_n = 1'b1;
        chk("rstmid_idle", bus.busy, 1'b0);
        run_vec(mk(1'b0, 1'b0, 64'h20, 64'h0, 64'h0, 1'b0), 10);

        // Fresh reset, then both requesters held: grant order and spacing.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) push_exp(1'b0, 64'hDEAD, 1'b0);
`else
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 64'hDEAD, 1'b0);
            push_exp(1'b1, 64'hBEEF, 1'b0);
        end
`endif
        drive(1'b0, 1'b1, 1'b0, 64'h08, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'h10, 64'd0);
        nacks = 0; nd = 0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.c_ack || bus.d_ack) begin
                chk("both_ack_time", k, 2 + 3 * nacks);
                nacks++;
                if (bus.d_ack) nd++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("both_ack_count", nacks, 4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        chk("both_dma_acks", nd, 0);
`else
        chk("both_dma_acks", nd, 2);
`endif
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
